// File: rtl/shield_dec_pkg.sv
// Shared constants and helpers for the multi-channel read decryptor front end.
package shield_dec_pkg;

    localparam int unsigned DEC_N_CH    = 4;
    localparam int unsigned DEC_DATA_W  = 512;
    localparam int unsigned DEC_MAX_OUT = 8;
    localparam int unsigned DEC_TAG_W   = 128;
    localparam int unsigned CH_ID_W     = $clog2(DEC_N_CH);

    // Channel id width; a single channel still needs one bit to carry an id.
    function automatic int unsigned ch_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Channel id to one-hot; callers slice off the channels they have.
    function automatic logic [15:0] id_onehot(input logic [3:0] id);
        return 16'h0001 << id;
    endfunction

endpackage

// File: rtl/shield_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a rotating pointer.
// The pointer moves past the winner only when the grant is taken (i_adv).
module shield_rr_arbiter
    import shield_dec_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N-1:0]            i_req,
    input  logic                    i_adv,
    output logic [N-1:0]            o_gnt,
    output logic [ch_id_w(N)-1:0]   o_gnt_id
);

    localparam int unsigned ID_W = ch_id_w(N);

    logic [ID_W-1:0] r_ptr;

    // Search requests starting at the pointer, wrapping at N.
    always_comb begin
        int unsigned     v_pos;
        logic [ID_W-1:0] v_idx;
        logic            v_found;
        o_gnt    = '0;
        o_gnt_id = '0;
        v_found  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            v_pos = 32'(r_ptr) + k;
            if (v_pos >= N) begin
                v_pos = v_pos - N;
            end
            v_idx = ID_W'(v_pos);
            if (!v_found && i_req[v_idx]) begin
                v_found         = 1'b1;
                o_gnt[v_idx]    = 1'b1;
                o_gnt_id        = v_idx;
            end
        end
    end

    // Advance the pointer to the channel after the winner on an accepted grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_adv && (|i_req)) begin
            r_ptr <= (o_gnt_id == ID_W'(N - 1)) ? '0 : o_gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/shield_read_decryptor_mc.sv
// Multi-channel front end sharing one pad/HMAC engine between N_CH read streams.
// Requests are arbitrated round-robin into a single issue slot; an in-order id FIFO
// routes each engine response back to the channel that issued it.
// Optional macro SHIELD_DEC_TAG_CMP_EN: store the expected tag per request and compare it.
module shield_read_decryptor_mc
    import shield_dec_pkg::*;
#(
    parameter int unsigned N_CH    = DEC_N_CH,
    parameter int unsigned DATA_W  = DEC_DATA_W,
    parameter int unsigned MAX_OUT = DEC_MAX_OUT,
    parameter int unsigned TAG_W   = DEC_TAG_W
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_CH*DATA_W-1:0]        i_req_data,
    input  logic [N_CH*32-1:0]            i_req_addr,
    input  logic [N_CH*32-1:0]            i_req_counter,
    input  logic [N_CH*64-1:0]            i_req_iv,
    input  logic [N_CH*TAG_W-1:0]         i_req_exp_tag,
    input  logic [N_CH-1:0]               i_req_val,
    output logic [N_CH-1:0]               o_req_rdy,
    output logic [DATA_W-1:0]             o_resp_pad,
    output logic [TAG_W-1:0]              o_resp_hmac_tag,
    output logic                          o_resp_tag_ok,
    output logic [N_CH-1:0]               o_resp_val,
    input  logic [N_CH-1:0]               i_resp_rdy,
    output logic [DATA_W-1:0]             o_eng_req_data,
    output logic [31:0]                   o_eng_req_addr,
    output logic [31:0]                   o_eng_req_counter,
    output logic [63:0]                   o_eng_req_iv,
    output logic                          o_eng_req_val,
    input  logic                          i_eng_req_rdy,
    input  logic [DATA_W-1:0]             i_eng_resp_pad,
    input  logic [TAG_W-1:0]              i_eng_resp_hmac_tag,
    input  logic                          i_eng_resp_val,
    output logic                          o_eng_resp_rdy,
    output logic [$clog2(MAX_OUT):0]      o_outstanding,
    output logic                          o_err_unexp
);

    localparam int unsigned ID_W  = ch_id_w(N_CH);
    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       addr;
        logic [31:0]       counter;
        logic [63:0]       iv;
    } dec_req_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
`ifdef SHIELD_DEC_TAG_CMP_EN
        logic [TAG_W-1:0]  exp_tag;
`endif
    } dec_fifo_ent_t;

    logic [N_CH-1:0]   w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_load_ok;
    logic              w_load;
    logic              w_eng_hs;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [CNT_W-1:0]  w_outstanding;
    logic [15:0]       w_oh;
    dec_req_t          w_sel_req;
    dec_fifo_ent_t     w_new_ent;
    dec_fifo_ent_t     w_head;

    logic              r_slot_val;
    dec_req_t          r_slot_req;
    dec_fifo_ent_t     r_slot_ent;
    dec_fifo_ent_t     r_fifo [MAX_OUT];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    // The slot counts as outstanding until it hands over to the FIFO, so a new load is
    // allowed only while slot + FIFO stay below MAX_OUT.
    assign w_outstanding = r_count + CNT_W'(r_slot_val);
    assign w_eng_hs      = r_slot_val & i_eng_req_rdy;
    assign w_load_ok     = (!r_slot_val || i_eng_req_rdy) && (w_outstanding < MAX_OUT_C);
    assign w_load        = w_load_ok & (|i_req_val);
    assign o_req_rdy     = w_load_ok ? w_gnt : '0;

    shield_rr_arbiter #(
        .N(N_CH)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req_val),
        .i_adv    (w_load_ok),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    // Pick the granted channel's request fields and FIFO entry.
    always_comb begin
        w_sel_req    = '0;
        w_new_ent    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) begin
                w_sel_req.data    = i_req_data[i*DATA_W +: DATA_W];
                w_sel_req.addr    = i_req_addr[i*32 +: 32];
                w_sel_req.counter = i_req_counter[i*32 +: 32];
                w_sel_req.iv      = i_req_iv[i*64 +: 64];
`ifdef SHIELD_DEC_TAG_CMP_EN
                w_new_ent.exp_tag = i_req_exp_tag[i*TAG_W +: TAG_W];
`endif
            end
        end
        w_new_ent.id = w_gnt_id;
    end

    // Issue slot: load on grant, otherwise empty once the engine takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_val <= 1'b0;
            r_slot_req <= '0;
            r_slot_ent <= '0;
        end else if (w_load) begin
            r_slot_val <= 1'b1;
            r_slot_req <= w_sel_req;
            r_slot_ent <= w_new_ent;
        end else if (w_eng_hs) begin
            r_slot_val <= 1'b0;
        end
    end

    assign o_eng_req_val     = r_slot_val;
    assign o_eng_req_data    = r_slot_req.data;
    assign o_eng_req_addr    = r_slot_req.addr;
    assign o_eng_req_counter = r_slot_req.counter;
    assign o_eng_req_iv      = r_slot_req.iv;

    // The id enters the FIFO when its request enters the engine.
    assign w_push  = w_eng_hs;
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];
    assign w_pop   = i_eng_resp_val & !w_empty & i_resp_rdy[w_head.id];

    // FIFO storage needs no reset; only pointers and count define its contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_slot_ent;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at MAX_OUT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A response with nothing outstanding is accepted and dropped, but flagged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (i_eng_resp_val && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign w_oh            = id_onehot(4'(w_head.id));
    assign o_eng_resp_rdy  = w_empty ? i_eng_resp_val : i_resp_rdy[w_head.id];
    assign o_resp_val      = (i_eng_resp_val && !w_empty) ? w_oh[N_CH-1:0] : '0;
    assign o_resp_pad      = i_eng_resp_pad;
    assign o_resp_hmac_tag = i_eng_resp_hmac_tag;
    assign o_outstanding   = w_outstanding;
    assign o_err_unexp     = r_err;

`ifdef SHIELD_DEC_TAG_CMP_EN
    assign o_resp_tag_ok = (i_eng_resp_hmac_tag == w_head.exp_tag);
    logic w_unused;
    assign w_unused = ^w_oh;
`else
    assign o_resp_tag_ok = 1'b1;
    logic w_unused;
    assign w_unused = ^{w_oh, i_req_exp_tag};
`endif

endmodule

// File: tb/tb_shield_read_decryptor_mc.sv
// Directed bench for shield_read_decryptor_mc with a small in-order engine model.
// The engine returns pad = data ^ {16{addr ^ counter}}, tag = {iv, addr, counter ^ 5a5a5a5a}.
module tb_shield_read_decryptor_mc;

    localparam int N_CH    = 4;
    localparam int DATA_W  = 512;
    localparam int MAX_OUT = 8;
    localparam int TAG_W   = 128;

    logic                   clk;
    logic                   rst_n;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH*32-1:0]     req_addr;
    logic [N_CH*32-1:0]     req_counter;
    logic [N_CH*64-1:0]     req_iv;
    logic [N_CH*TAG_W-1:0]  req_exp_tag;
    logic [N_CH-1:0]        req_val;
    logic [N_CH-1:0]        req_rdy;
    logic [DATA_W-1:0]      resp_pad;
    logic [TAG_W-1:0]       resp_hmac_tag;
    logic                   resp_tag_ok;
    logic [N_CH-1:0]        resp_val;
    logic [N_CH-1:0]        resp_rdy;
    logic [DATA_W-1:0]      eng_req_data;
    logic [31:0]            eng_req_addr;
    logic [31:0]            eng_req_counter;
    logic [63:0]            eng_req_iv;
    logic                   eng_req_val;
    logic                   eng_req_rdy;
    logic [DATA_W-1:0]      eng_resp_pad;
    logic [TAG_W-1:0]       eng_resp_hmac_tag;
    logic                   eng_resp_val;
    logic                   eng_resp_rdy;
    logic [3:0]             outstanding;
    logic                   err_unexp;

    int checks;
    int errors;

    logic [DATA_W-1:0] in_data [4];
    logic [31:0]       in_addr [4];
    logic [31:0]       in_ctr  [4];
    logic [63:0]       in_iv   [4];
    logic [DATA_W-1:0] exp_pad [4];
    logic [TAG_W-1:0]  exp_tag [4];

    shield_read_decryptor_mc #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .MAX_OUT (MAX_OUT),
        .TAG_W   (TAG_W)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_req_data          (req_data),
        .i_req_addr          (req_addr),
        .i_req_counter       (req_counter),
        .i_req_iv            (req_iv),
        .i_req_exp_tag       (req_exp_tag),
        .i_req_val           (req_val),
        .o_req_rdy           (req_rdy),
        .o_resp_pad          (resp_pad),
        .o_resp_hmac_tag     (resp_hmac_tag),
        .o_resp_tag_ok       (resp_tag_ok),
        .o_resp_val          (resp_val),
        .i_resp_rdy          (resp_rdy),
        .o_eng_req_data      (eng_req_data),
        .o_eng_req_addr      (eng_req_addr),
        .o_eng_req_counter   (eng_req_counter),
        .o_eng_req_iv        (eng_req_iv),
        .o_eng_req_val       (eng_req_val),
        .i_eng_req_rdy       (eng_req_rdy),
        .i_eng_resp_pad      (eng_resp_pad),
        .i_eng_resp_hmac_tag (eng_resp_hmac_tag),
        .i_eng_resp_val      (eng_resp_val),
        .o_eng_resp_rdy      (eng_resp_rdy),
        .o_outstanding       (outstanding),
        .o_err_unexp         (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    typedef struct {
        logic [DATA_W-1:0] pad;
        logic [TAG_W-1:0]  tag;
    } eng_ent_t;

    eng_ent_t eng_q[$];
    bit       eng_go;
    bit       eng_force;

    function automatic eng_ent_t eng_model(logic [DATA_W-1:0] d, logic [31:0] a,
                                           logic [31:0] c, logic [63:0] iv);
        eng_ent_t e;
        e.pad = d ^ {16{a ^ c}};
        e.tag = {iv, a, c ^ 32'h5a5a5a5a};
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            eng_q.delete();
        end else begin
            if (eng_resp_val && eng_resp_rdy && !eng_force && eng_q.size() > 0) begin
                eng_q.delete(0);
            end
            if (eng_req_val && eng_req_rdy) begin
                eng_q.push_back(eng_model(eng_req_data, eng_req_addr, eng_req_counter, eng_req_iv));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            eng_resp_val      = 1'b0;
            eng_resp_pad      = '0;
            eng_resp_hmac_tag = '0;
        end else begin
            eng_resp_val = eng_force || (eng_go && eng_q.size() > 0);
            if (eng_q.size() > 0) begin
                eng_resp_pad      = eng_q[0].pad;
                eng_resp_hmac_tag = eng_q[0].tag;
            end else begin
                eng_resp_pad      = '0;
                eng_resp_hmac_tag = '0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic init_tables;
        in_data[0] = '0;                    in_addr[0] = 32'h0;
        in_ctr[0]  = 32'h0;                 in_iv[0]   = 64'h0;
        in_data[1] = {16{32'h01234567}};    in_addr[1] = 32'habcdef01;
        in_ctr[1]  = 32'h23456789;          in_iv[1]   = 64'hdeadbeefdeadbeef;
        in_data[2] = {16{32'h36363636}};    in_addr[2] = 32'hcccccccc;
        in_ctr[2]  = 32'h01010101;          in_iv[2]   = 64'h00001111aaaabbbb;
        in_data[3] = {16{32'hffffffff}};    in_addr[3] = 32'h00000010;
        in_ctr[3]  = 32'h00000001;          in_iv[3]   = 64'h0123456789abcdef;
        // Hand-computed engine results for the vectors above.
        exp_pad[0] = '0;
        exp_tag[0] = {64'h0, 32'h0, 32'h5a5a5a5a};
        exp_pad[1] = {16{32'h89abcdef}};
        exp_tag[1] = {64'hdeadbeefdeadbeef, 32'habcdef01, 32'h791f3dd3};
        exp_pad[2] = {16{32'hfbfbfbfb}};
        exp_tag[2] = {64'h00001111aaaabbbb, 32'hcccccccc, 32'h5b5b5b5b};
        exp_pad[3] = {16{32'hffffffee}};
        exp_tag[3] = {64'h0123456789abcdef, 32'h00000010, 32'h5a5a5a5b};
    endtask

    task automatic set_ch(input int ch);
        req_data[ch*DATA_W +: DATA_W]  = in_data[ch];
        req_addr[ch*32 +: 32]          = in_addr[ch];
        req_counter[ch*32 +: 32]       = in_ctr[ch];
        req_iv[ch*64 +: 64]            = in_iv[ch];
        req_exp_tag[ch*TAG_W +: TAG_W] = exp_tag[ch];
    endtask

    task automatic do_reset;
        rst_n       = 1'b0;
        req_val     = '0;
        resp_rdy    = '1;
        eng_go      = 1'b0;
        eng_force   = 1'b0;
        eng_req_rdy = 1'b1;
        for (int c = 0; c < 4; c++) set_ch(c);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (resp_val != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset();
        checks++;
        if ({req_rdy, eng_req_val, eng_resp_rdy, resp_val} !== 10'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b want 0", {req_rdy, eng_req_val, eng_resp_rdy, resp_val});
        end
        checks++;
        if (outstanding !== 4'd0 || err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outstanding %0d err %b want 0 0", outstanding, err_unexp);
        end
    endtask

    task automatic test_single;
        bit ok;
        do_reset();
        eng_go  = 1'b1;
        req_val = 4'b0001;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL single_rdy: got %b want 0001", req_rdy);
        end
        tick();
        req_val = '0;
        checks++;
        if (eng_req_val !== 1'b1 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL single_issue: val %b outstanding %0d want 1 1", eng_req_val, outstanding);
        end
        wait_resp(ok);
        checks++;
        if (!ok || resp_val !== 4'b0001) begin
            errors++;
            $display("FAIL single_resp_val: got %b want 0001", resp_val);
        end
        checks++;
        if (resp_pad !== exp_pad[0] || resp_hmac_tag !== exp_tag[0] || resp_tag_ok !== 1'b1) begin
            errors++;
            $display("FAIL single_payload: tag %h ok %b want %h 1", resp_hmac_tag, resp_tag_ok, exp_tag[0]);
        end
        tick();
        tick();
        checks++;
        if (resp_val !== 4'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL single_done: resp_val %b outstanding %0d want 0 0", resp_val, outstanding);
        end
    endtask

    task automatic test_all_ch;
        int  order[4];
        int  n;
        bit  ok;
        logic [3:0] gmask;
        do_reset();
        req_val = 4'b1111;
        n = 0;
        for (int c = 0; c < 16 && n < 4; c++) begin
            #1;
            gmask = req_rdy;
            if (gmask != '0) begin
                order[n] = oh2idx(gmask);
                n++;
            end
            tick();
            req_val = req_val & ~gmask;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL all_grant_count: got %0d want 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k < n && order[k] !== k) begin
                errors++;
                $display("FAIL all_grant_order[%0d]: got %0d want %0d", k, order[k], k);
            end
        end
        eng_go = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_resp(ok);
            checks++;
            if (!ok || resp_val !== 4'(1 << k)) begin
                errors++;
                $display("FAIL all_resp_val[%0d]: got %b want %b", k, resp_val, 4'(1 << k));
            end
            checks++;
            if (resp_pad !== exp_pad[k] || resp_hmac_tag !== exp_tag[k]) begin
                errors++;
                $display("FAIL all_resp_payload[%0d]: tag %h want %h", k, resp_hmac_tag, exp_tag[k]);
            end
        end
    endtask

    task automatic test_saturate;
        int  grants;
        int  max_out;
        bit  ok;
        do_reset();
        eng_req_rdy = 1'b0;
        req_val     = 4'b1111;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL sat_first_rdy: got %b want 0001", req_rdy);
        end
        tick();
        // Slot holds ch0 while the engine stalls; ch0 inputs change underneath.
        req_addr[31:0]    = 32'h77;
        req_counter[31:0] = 32'h55;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_rdy !== 4'b0 || eng_req_val !== 1'b1 || outstanding !== 4'd1) begin
                errors++;
                $display("FAIL sat_stall[%0d]: rdy %b val %b outstanding %0d want 0000 1 1",
                         c, req_rdy, eng_req_val, outstanding);
            end
            checks++;
            if (eng_req_addr !== 32'h0 || eng_req_counter !== 32'h0) begin
                errors++;
                $display("FAIL sat_stable[%0d]: addr %h ctr %h want 0 0", c, eng_req_addr, eng_req_counter);
            end
            tick();
        end
        set_ch(0);
        eng_req_rdy = 1'b1;
        grants      = 1;
        max_out     = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_rdy != '0) grants++;
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
            tick();
        end
        checks++;
        if (grants !== MAX_OUT || max_out !== MAX_OUT) begin
            errors++;
            $display("FAIL sat_count: grants %0d max %0d want 8 8", grants, max_out);
        end
        checks++;
        if (outstanding !== 4'd8 || req_rdy !== 4'b0) begin
            errors++;
            $display("FAIL sat_full: outstanding %0d rdy %b want 8 0000", outstanding, req_rdy);
        end
        req_val = '0;
        eng_go  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_resp(ok);
            checks++;
            if (!ok || resp_val !== 4'(1 << (k % 4)) || resp_hmac_tag !== exp_tag[k % 4]) begin
                errors++;
                $display("FAIL sat_drain[%0d]: val %b tag %h want %b %h",
                         k, resp_val, resp_hmac_tag, 4'(1 << (k % 4)), exp_tag[k % 4]);
            end
        end
        tick();
        tick();
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL sat_empty: outstanding %0d want 0", outstanding);
        end
    endtask

    task automatic test_hol;
        bit ok;
        do_reset();
        resp_rdy = 4'b1101;
        req_val  = 4'b0110;
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL hol_grant1: got %b want 0010", req_rdy);
        end
        tick();
        req_val = 4'b0100;
        checks++;
        if (eng_req_data !== in_data[1] || eng_req_addr !== in_addr[1] ||
            eng_req_counter !== in_ctr[1] || eng_req_iv !== in_iv[1]) begin
            errors++;
            $display("FAIL hol_eng_fields: addr %h ctr %h iv %h want %h %h %h",
                     eng_req_addr, eng_req_counter, eng_req_iv, in_addr[1], in_ctr[1], in_iv[1]);
        end
        #1;
        checks++;
        if (req_rdy !== 4'b0100) begin
            errors++;
            $display("FAIL hol_grant2: got %b want 0100", req_rdy);
        end
        tick();
        req_val = '0;
        repeat (3) tick();
        eng_go = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (resp_val !== 4'b0010 || eng_resp_rdy !== 1'b0 || outstanding !== 4'd2) begin
                errors++;
                $display("FAIL hol_blocked[%0d]: val %b rdy %b outstanding %0d want 0010 0 2",
                         c, resp_val, eng_resp_rdy, outstanding);
            end
        end
        resp_rdy = 4'b1111;
        #1;
        checks++;
        if (eng_resp_rdy !== 1'b1 || resp_pad !== exp_pad[1]) begin
            errors++;
            $display("FAIL hol_release: rdy %b want 1", eng_resp_rdy);
        end
        wait_resp(ok);
        checks++;
        if (!ok || resp_val !== 4'b0100 || resp_pad !== exp_pad[2] || resp_hmac_tag !== exp_tag[2]) begin
            errors++;
            $display("FAIL hol_ch2: val %b tag %h want 0100 %h", resp_val, resp_hmac_tag, exp_tag[2]);
        end
    endtask

    task automatic test_unexp;
        do_reset();
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL unexp_clear: got %b want 0", err_unexp);
        end
        eng_force = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (eng_resp_rdy !== 1'b1 || resp_val !== 4'b0) begin
            errors++;
            $display("FAIL unexp_drop: rdy %b val %b want 1 0000", eng_resp_rdy, resp_val);
        end
        tick();
        eng_force = 1'b0;
        checks++;
        if (err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL unexp_set: got %b want 1", err_unexp);
        end
        repeat (4) tick();
        checks++;
        if (err_unexp !== 1'b1 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL unexp_sticky: err %b outstanding %0d want 1 0", err_unexp, outstanding);
        end
        do_reset();
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL unexp_reset: got %b want 0", err_unexp);
        end
    endtask

`ifdef SHIELD_DEC_TAG_CMP_EN
    task automatic test_tag_cmp;
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            eng_go = 1'b1;
            req_exp_tag[TAG_W-1:0] = exp_tag[0] ^ TAG_W'(pass);
            req_val = 4'b0001;
            tick();
            req_val = '0;
            wait_resp(ok);
            checks++;
            if (!ok || resp_tag_ok !== (pass == 0)) begin
                errors++;
                $display("FAIL tag_cmp[%0d]: got %b want %b", pass, resp_tag_ok, (pass == 0));
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        req_data    = '0;
        req_addr    = '0;
        req_counter = '0;
        req_iv      = '0;
        req_exp_tag = '0;
        init_tables();
        test_reset();
        test_single();
        test_all_ch();
        test_saturate();
        test_hol();
        test_unexp();
`ifdef SHIELD_DEC_TAG_CMP_EN
        test_tag_cmp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
